// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants, FSM state encodings and datapath width for the ALU arbiter.
package alu_pkg;

    localparam int DW = 32;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_INC = 3'd2;
    localparam logic [2:0] OP_DEC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_NOT = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// alu: shared combinational ALU; 33-bit result with carry/borrow in bit 32, outputs forced to zero when disabled.
module alu
    import alu_pkg::*;
(
    input  logic          enable,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [2:0]    opcode,
    output logic          zf,
    output logic          cf,
    output logic [DW:0]   res
);

    logic [DW:0] r;
    logic [DW:0] ax;
    logic [DW:0] bx;

    assign ax = {1'b0, a};
    assign bx = {1'b0, b};

    always_comb begin
        r = '0;
        case (opcode)
            OP_ADD:  r = ax + bx;
            OP_SUB:  r = ax - bx;
            OP_INC:  r = ax + (DW+1)'(1);
            OP_DEC:  r = ax - (DW+1)'(1);
            OP_AND:  r = ax & bx;
            OP_OR:   r = ax | bx;
            OP_NOT:  r = {1'b0, ~a};
            OP_XOR:  r = ax ^ bx;
            default: r = '0;
        endcase
    end

    assign res = enable ? r : '0;
    assign zf  = enable && (r[DW-1:0] == '0);
    assign cf  = enable && r[DW];

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbitration of two requesters onto one shared ALU,
// with an IDLE -> EXEC -> RESP handshake FSM and registered response outputs.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req1_valid,
    output logic          req0_ready,
    output logic          req1_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [2:0]    req0_op,
    input  logic [2:0]    req1_op,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW:0]   rsp_res,
    output logic          rsp_zf,
    output logic          rsp_cf
);

    localparam logic [1:0] CNT_INIT = 2'(ALU_LAT - 1);

    state_t        state;
    logic [1:0]    cnt;
    logic          last;
    logic          id;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [2:0]    op_q;
    logic          alu_en;
    logic          alu_zf;
    logic          alu_cf;
    logic [DW:0]   alu_res;
    logic          idle;
    logic          g0;
    logic          g1;

    // last holds the most recently served id; reset value 1 gives req0 first priority
    assign g0         = req0_valid && (!req1_valid || last);
    assign g1         = req1_valid && (!req0_valid || !last);
    assign idle       = (state == ST_IDLE) && !rst;
    assign req0_ready = idle && g0;
    assign req1_ready = idle && g1;
    assign alu_en     = (state == ST_EXEC) && !rst;

    alu u_alu (
        .enable (alu_en),
        .a      (a_q),
        .b      (b_q),
        .opcode (op_q),
        .zf     (alu_zf),
        .cf     (alu_cf),
        .res    (alu_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            id        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_res   <= '0;
            rsp_zf    <= 1'b0;
            rsp_cf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        id    <= req1_ready;
                        a_q   <= req1_ready ? req1_a : req0_a;
                        b_q   <= req1_ready ? req1_b : req0_b;
                        op_q  <= req1_ready ? req1_op : req0_op;
                        cnt   <= CNT_INIT;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt == 2'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= id;
                        rsp_res   <= alu_res;
                        rsp_zf    <= alu_zf;
                        rsp_cf    <= alu_cf;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        last      <= rsp_id;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table-driven checks of arbitration, latency, ALU results, stall and reset.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] res;
        logic        zf;
        logic        cf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic        rsp_ready = 1'b1;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zf, rsp_cf;
    logic [32:0] rsp_res;
    logic        r0_ready3, r1_ready3, rsp_valid3, rsp_id3, rsp_zf3, rsp_cf3;
    logic [32:0] rsp_res3;

    int n_chk = 0;
    int n_fail = 0;
    vec_t tbl[12];

    always #5 clk = ~clk;

    alu_arbiter #(.ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_zf(rsp_zf), .rsp_cf(rsp_cf)
    );

    alu_arbiter #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(r0_ready3), .req1_ready(r1_ready3),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_id(rsp_id3),
        .rsp_res(rsp_res3), .rsp_zf(rsp_zf3), .rsp_cf(rsp_cf3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_seen", rsp_valid, 1);
    endtask

    task automatic wait_grant();
        int n = 0;
        while (!(req0_ready || req1_ready) && n < 12) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        @(negedge clk);
        set_req(v.id, v.op, v.a, v.b);
        #1;
        wait_grant();
        chk({tag, " grant"}, v.id ? req1_ready : req0_ready, 1);
        chk({tag, " other_ready"}, v.id ? req0_ready : req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(n);
        chk({tag, " latency"}, 64'(n), 2);
        chk({tag, " rsp_id"}, rsp_id, v.id);
        chk({tag, " rsp_res"}, rsp_res, v.res);
        chk({tag, " rsp_zf"}, rsp_zf, v.zf);
        chk({tag, " rsp_cf"}, rsp_cf, v.cf);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [32:0] held;
        tbl[0]  = '{1'b0, OP_ADD, 32'h0000_00A5, 32'h0000_000F, 33'h0_0000_00B4, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, OP_SUB, 32'h0000_00A5, 32'h0000_000F, 33'h0_0000_0096, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, OP_INC, 32'hFFFF_FFFF, 32'h0000_0000, 33'h1_0000_0000, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, OP_DEC, 32'h0000_0000, 32'h0000_0000, 33'h1_FFFF_FFFF, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 33'h0_F000_F000, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, OP_OR,  32'h0F0F_0000, 32'h0000_00F0, 33'h0_0F0F_00F0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, OP_NOT, 32'h0000_FFFF, 32'h1234_5678, 33'h0_FFFF_0000, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, OP_XOR, 32'h0000_00A5, 32'h0000_000F, 33'h0_0000_00AA, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, OP_SUB, 32'h0000_0005, 32'h0000_0005, 33'h0_0000_0000, 1'b1, 1'b0};
        tbl[10] = '{1'b0, OP_SUB, 32'h0000_0000, 32'h0000_0001, 33'h1_FFFF_FFFF, 1'b0, 1'b1};
        tbl[11] = '{1'b1, OP_NOT, 32'hFFFF_FFFF, 32'h0000_0000, 33'h0_0000_0000, 1'b1, 1'b0};

        // reset state, readys held low with both requests pending
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("rst req0_ready", req0_ready, 0);
        chk("rst req1_ready", req1_ready, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_id", rsp_id, 0);
        chk("rst rsp_res", rsp_res, 0);
        chk("rst rsp_zf", rsp_zf, 0);
        chk("rst rsp_cf", rsp_cf, 0);
        chk("rst dut3 readys", {r0_ready3, r1_ready3}, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // simultaneous requests: req0 first after reset, then req1
        do_reset();
        set_req(1'b0, OP_SUB, 32'hA5, 32'h0F);
        set_req(1'b1, OP_XOR, 32'hA5, 32'h0F);
        #1;
        chk("both first req0_ready", req0_ready, 1);
        chk("both first req1_ready", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(n);
        chk("both first rsp_id", rsp_id, 0);
        chk("both first rsp_res", rsp_res, 33'h096);
        @(posedge clk); #1;
        chk("both second req1_ready", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_rsp(n);
        chk("both second rsp_id", rsp_id, 1);
        chk("both second rsp_res", rsp_res, 33'h0AA);
        @(posedge clk); #1;

        // continuous contention alternates grants
        do_reset();
        set_req(1'b0, OP_ADD, 32'h1, 32'h2);
        set_req(1'b1, OP_ADD, 32'h3, 32'h4);
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_grant();
            chk($sformatf("rr%0d grant_is_req1", k), req1_ready, 64'(k % 2));
            chk($sformatf("rr%0d single_grant", k), req0_ready & req1_ready, 0);
            @(posedge clk); #1;
            wait_rsp(n);
            chk($sformatf("rr%0d rsp_res", k), rsp_res, (k % 2) ? 33'h7 : 33'h3);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // response stall: outputs stable for five cycles, nothing accepted
        do_reset();
        rsp_ready = 1'b0;
        set_req(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h1);
        #1;
        wait_grant();
        chk("stall grant", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        set_req(1'b1, OP_ADD, 32'h1, 32'h2);
        wait_rsp(n);
        held = rsp_res;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d rsp_valid", i), rsp_valid, 1);
            chk($sformatf("stall%0d rsp_res", i), rsp_res, 33'h1_0000_0000);
            chk($sformatf("stall%0d flags", i), {rsp_id, rsp_zf, rsp_cf}, 3'b011);
            chk($sformatf("stall%0d readys", i), {req0_ready, req1_ready}, 0);
            @(negedge clk);
        end
        chk("stall held res", held, 33'h1_0000_0000);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall done rsp_valid", rsp_valid, 0);
        chk("stall done req1_ready", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_rsp(n);
        chk("stall next rsp_id", rsp_id, 1);
        chk("stall next rsp_res", rsp_res, 33'h3);
        @(posedge clk); #1;

        // ALU_LAT=3: latency, then reset mid-EXEC discards and restores req0 priority
        do_reset();
        set_req(1'b0, OP_ADD, 32'h1, 32'h1);
        #1;
        chk("lat3 grant", r0_ready3, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n = 0;
        while (!rsp_valid3 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("lat3 latency", 64'(n), 4);
        chk("lat3 rsp_res", rsp_res3, 33'h2);
        @(posedge clk); #1;
        set_req(1'b0, OP_ADD, 32'h5, 32'h6);
        set_req(1'b1, OP_SUB, 32'h9, 32'h4);
        #1;
        chk("lat3 rr req1_ready", r1_ready3, 1);
        chk("lat3 rr req0_ready", r0_ready3, 0);
        @(posedge clk); #1;
        chk("lat3 exec alu_en", dut3.alu_en, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("lat3 rst alu_en", dut3.alu_en, 0);
        chk("lat3 rst readys", {r0_ready3, r1_ready3}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("lat3 post rsp_valid", rsp_valid3, 0);
        chk("lat3 post req0_ready", r0_ready3, 1);
        chk("lat3 post req1_ready", r1_ready3, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("lat3 discard%0d", i), rsp_valid3, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
